// File: rtl/mul_div_controller_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : mul_div_controller_pkg
// Brief   : Shared opcodes, FSM state encoding and sizing for the MUL/DIV unit.
// Revision: 1.0 - initial release
// ============================================================================
package mul_div_controller_pkg;

    localparam int unsigned c_DEFAULT_WIDTH = 32;
    localparam int unsigned c_STEP_CNT_W    = 6;

    localparam logic [1:0] c_OP_MUL = 2'b00;
    localparam logic [1:0] c_OP_DIV = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MUL_WAIT = 3'd1,
        ST_DIV_RUN  = 3'd2,
        ST_DIV_FIX  = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    // Both 2'b10 and 2'b11 are reserved encodings.
    function automatic logic is_illegal_op(input logic [1:0] op_code);
        return op_code[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mul_div_controller_booth_mul.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : mul_div_controller_booth_mul
// Brief   : Combinational signed radix-4 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Revision: 1.0 - initial release
// ============================================================================
module mul_div_controller_booth_mul #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [2*WIDTH-1:0] o_prod
);

    localparam int c_DIGITS = WIDTH / 2;

    logic [2*WIDTH-1:0] w_a_ext;
    logic [WIDTH:0]     w_b_ext;
    logic [2*WIDTH-1:0] w_pp [c_DIGITS];
    logic [2*WIDTH-1:0] w_sum;

    assign w_a_ext = {{WIDTH{i_a[WIDTH-1]}}, i_a};
    assign w_b_ext = {i_b, 1'b0};

    function automatic logic [2*WIDTH-1:0] booth_term(input logic [2:0] sel,
                                                     input logic [2*WIDTH-1:0] mcand);
        logic [2*WIDTH-1:0] mag;
        mag = '0;
        case (sel)
            3'b001, 3'b010, 3'b101, 3'b110: mag = mcand;
            3'b011, 3'b100:                 mag = mcand << 1;
            default:                        mag = '0;
        endcase
        return sel[2] ? (~mag + 1'b1) : mag;
    endfunction

    generate
        for (genvar g = 0; g < c_DIGITS; g++) begin : g_pp
            assign w_pp[g] = booth_term(w_b_ext[2*g+2 -: 3], w_a_ext) << (2*g);
        end
    endgenerate

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < c_DIGITS; i++) begin
            w_sum = w_sum + w_pp[i];
        end
    end

    assign o_prod = w_sum;

endmodule
`default_nettype wire

// File: rtl/mul_div_controller_div_step.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : mul_div_controller_div_step
// Brief   : One combinational non-restoring divide iteration on magnitudes.
// Revision: 1.0 - initial release
// ============================================================================
module mul_div_controller_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH:0]   i_divisor,
    output logic [WIDTH:0]   o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0] w_shifted;

    assign w_shifted = {i_rem[WIDTH-1:0], i_quo[WIDTH-1]};

    // A negative partial remainder is repaired by adding on the next step
    // instead of restoring immediately.
    assign o_rem = i_rem[WIDTH] ? (w_shifted + i_divisor) : (w_shifted - i_divisor);
    assign o_quo = {i_quo[WIDTH-2:0], ~o_rem[WIDTH]};

endmodule
`default_nettype wire

// File: rtl/mul_div_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : mul_div_controller
// Brief   : Sequencer for the MUL/DIV unit: multicycle Booth MUL, iterative signed DIV.
// Revision: 1.0 - initial release
// ============================================================================
module mul_div_controller
    import mul_div_controller_pkg::*;
#(
    parameter int WIDTH   = c_DEFAULT_WIDTH,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero,
    output logic             bad_op
);

    localparam int c_CNT_MAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH:0]     r_div;
    logic               r_sign_q;
    logic               r_sign_r;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_dbz;
    logic               r_bad;

    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH:0]     w_rem_nxt;
    logic [WIDTH-1:0]   w_quo_nxt;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_quo_res;
    logic [WIDTH-1:0]   w_rem_res;

    mul_div_controller_booth_mul #(
        .WIDTH (WIDTH)
    ) u_booth_mul (
        .i_a    (r_a),
        .i_b    (r_b),
        .o_prod (w_prod)
    );

    mul_div_controller_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_div),
        .o_rem     (w_rem_nxt),
        .o_quo     (w_quo_nxt)
    );

    // The most negative operand maps onto 2**(WIDTH-1), which is exact as unsigned.
    assign w_abs_a = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign w_abs_b = b[WIDTH-1] ? (~b + 1'b1) : b;

    // Final remainder is below the divisor, so the correction fits in WIDTH bits.
    assign w_rem_fix = r_rem[WIDTH] ? (r_rem[WIDTH-1:0] + r_div[WIDTH-1:0]) : r_rem[WIDTH-1:0];
    assign w_quo_res = r_sign_q ? (~r_quo + 1'b1) : r_quo;
    assign w_rem_res = r_sign_r ? (~w_rem_fix + 1'b1) : w_rem_fix;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_dbz    <= 1'b0;
            r_bad    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        r_a    <= a;
                        r_b    <= b;
                        if (op == c_OP_MUL) begin
                            r_cnt   <= c_CNT_W'(MUL_LAT - 1);
                            r_state <= ST_MUL_WAIT;
                        end else if (!is_illegal_op(op) && (b != '0)) begin
                            r_rem    <= '0;
                            r_quo    <= w_abs_a;
                            r_div    <= {1'b0, w_abs_b};
                            r_sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
                            r_sign_r <= a[WIDTH-1];
                            r_cnt    <= c_CNT_W'(WIDTH - 1);
                            r_state  <= ST_DIV_RUN;
                        end else begin
                            // Divide by zero and illegal ops complete without iterating.
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_dbz   <= !is_illegal_op(op);
                            r_bad   <= is_illegal_op(op);
                            r_hi    <= is_illegal_op(op) ? '0 : a;
                            r_lo    <= is_illegal_op(op) ? '0 : '1;
                        end
                    end
                end
                ST_MUL_WAIT: begin
                    if (r_cnt == '0) begin
                        {r_hi, r_lo} <= w_prod;
                        r_dbz        <= 1'b0;
                        r_bad        <= 1'b0;
                        r_done       <= 1'b1;
                        r_state      <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DIV_RUN: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    if (r_cnt == '0) begin
                        r_state <= ST_DIV_FIX;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DIV_FIX: begin
                    r_hi    <= w_rem_res;
                    r_lo    <= w_quo_res;
                    r_dbz   <= 1'b0;
                    r_bad   <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign div_by_zero = r_dbz;
    assign bad_op      = r_bad;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_mul_div_controller
// Brief   : Scoreboard bench for mul_div_controller with directed MUL/DIV vectors.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mul_div_controller;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_by_zero;
    logic        bad_op;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        logic        bad;
        int          cyc;
        string       name;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    mul_div_controller #(
        .WIDTH   (32),
        .MUL_LAT (2)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero),
        .bad_op      (bad_op)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!clr && done === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pulse", cyc);
            end else begin
                m_e = q.pop_front();
                check({m_e.name, "_hi"},  64'(hi),          64'(m_e.hi));
                check({m_e.name, "_lo"},  64'(lo),          64'(m_e.lo));
                check({m_e.name, "_dbz"}, 64'(div_by_zero), 64'(m_e.dbz));
                check({m_e.name, "_bad"}, 64'(bad_op),      64'(m_e.bad));
                check({m_e.name, "_cyc"}, 64'(cyc),         64'(m_e.cyc));
                check({m_e.name, "_busy"}, 64'(busy),       64'd1);
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy=%b expected 0 within 200 cycles", busy);
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eh, input logic [31:0] el,
                         input logic ed, input logic eb, input int lat, input string nm);
        exp_t e;
        wait_idle();
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start  = 1'b0;
        e.hi   = eh;
        e.lo   = el;
        e.dbz  = ed;
        e.bad  = eb;
        e.cyc  = cyc + lat - 1;
        e.name = nm;
        q.push_back(e);
        check({nm, "_accept_busy"}, 64'(busy), 64'd1);
    endtask

    initial begin
        #500000;
        checks++;
        errors++;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy),        64'd0);
        check("rst_done", 64'(done),        64'd0);
        check("rst_hi",   64'(hi),          64'd0);
        check("rst_lo",   64'(lo),          64'd0);
        check("rst_dbz",  64'(div_by_zero), 64'd0);
        check("rst_bad",  64'(bad_op),      64'd0);
        clr = 1'b0;

        issue(2'b00, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0, 3,  "mul_7_m3");
        issue(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0, 3,  "mul_min_min");
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0, 3,  "mul_m1_m1");
        issue(2'b01, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, 34, "div_m7_2");
        issue(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0, 34, "div_min_m1");
        issue(2'b01, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 1'b0, 34, "div_7_m2");
        issue(2'b01, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 1'b0, 34, "div_100_7");

        // Abort: DIV accepted at T, ignored starts T+1..T+5, clr at T+10.
        wait_idle();
        start = 1'b1;
        op    = 2'b01;
        a     = 32'hFFFF_FFF9;
        b     = 32'd2;
        @(posedge clk);
        #1;
        op = 2'b00;
        a  = 32'd1;
        b  = 32'd1;
        check("abort_busy_t1", 64'(busy), 64'd1);
        repeat (5) @(posedge clk);
        #1;
        start = 1'b0;
        check("abort_busy_t6", 64'(busy), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hi",   64'(hi),   64'd0);
        check("abort_lo",   64'(lo),   64'd0);
        issue(2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0, 3, "mul_after_abort");

        issue(2'b01, 32'd5,  32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1'b0, 1, "div_by_zero");
        issue(2'b11, 32'd9,  32'd3, 32'd0, 32'd0,         1'b0, 1'b1, 1, "bad_op_11");
        issue(2'b10, 32'd12, 32'd4, 32'd0, 32'd0,         1'b0, 1'b1, 1, "bad_op_10");
        issue(2'b01, 32'd12, 32'd4, 32'd0, 32'd3,         1'b0, 1'b0, 34, "div_12_4");

        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("queue_drained", 64'(q.size()), 64'd0);
        wait_idle();
        check("end_busy", 64'(busy), 64'd0);
        check("end_hold_lo", 64'(lo), 64'd3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
